// File: rtl/conway_board_reader.sv
// ---------------------------------------------------------------------------
// conway_board_reader
//
// Read-side companion to the Game of Life cell array. A start pulse in IDLE
// snapshots the whole parallel board; the snapshot is then streamed out one
// row per beat over a valid/ready handshake. Because the board is captured
// once, every frame is a single consistent generation even while the array
// keeps stepping underneath.
//
// Parameters:
//   ROWS  number of board rows (>= 2)
//   COLS  number of board columns, i.e. bits per row beat (>= 1)
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset (discards any partial frame)
//   start      frame readout request, only honoured in IDLE
//   board_in   live cell states, cell (r,c) = board_in[r*COLS + c]
//   busy       high from the cycle after start acceptance until back in IDLE
//   row_valid  a row beat is presented
//   row_ready  consumer accepts the beat
//   row_data   snapshot row, bit c = column c
//   row_addr   index of the row presented
//   row_first  row_valid and row_addr == 0
//   row_last   row_valid and row_addr == ROWS-1
//   done       one-cycle pulse after the final row handshake
//
// Optional build macro CONWAY_READER_POPCOUNT_EN adds:
//   row_live    number of live cells in the presented row
//   frame_live  number of live cells in the snapshot, captured with it
// ---------------------------------------------------------------------------
module conway_board_reader #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROWS*COLS-1:0]      board_in,
    output logic                      busy,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [COLS-1:0]           row_data,
    output logic [$clog2(ROWS)-1:0]   row_addr,
    output logic                      row_first,
    output logic                      row_last,
`ifdef CONWAY_READER_POPCOUNT_EN
    output logic [$clog2(COLS+1)-1:0]      row_live,
    output logic [$clog2(ROWS*COLS+1)-1:0] frame_live,
`endif
    output logic                      done
);

    localparam int ADDR_W = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ROWS*COLS-1:0]   snapshot_q;
    logic [ADDR_W-1:0]      row_addr_q;
    logic                   busy_q;
    logic                   row_valid_q;
    logic                   row_first_q;
    logic                   row_last_q;
    logic                   done_q;

    // -----------------------------------------------------------------------
    // Control FSM. All handshake flags are registered alongside the state so
    // no output depends combinationally on row_ready.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snapshot_q  <= '0;
            row_addr_q  <= '0;
            busy_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_first_q <= 1'b0;
            row_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        snapshot_q  <= board_in;
                        row_addr_q  <= '0;
                        state_q     <= SEND;
                        busy_q      <= 1'b1;
                        row_valid_q <= 1'b1;
                        row_first_q <= 1'b1;
                        row_last_q  <= 1'b0;  // ROWS >= 2, row 0 is never last
                    end
                end

                SEND: begin
                    if (row_ready) begin
                        if (row_addr_q == LAST_ROW) begin
                            state_q     <= DONE;
                            row_valid_q <= 1'b0;
                            row_first_q <= 1'b0;
                            row_last_q  <= 1'b0;
                            row_addr_q  <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            // Increment stops at LAST_ROW, so the row mux
                            // never indexes past the snapshot even when ROWS
                            // is not a power of two.
                            row_addr_q  <= row_addr_q + ADDR_W'(1);
                            row_first_q <= 1'b0;
                            row_last_q  <= ((row_addr_q + ADDR_W'(1)) == LAST_ROW);
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    row_valid_q <= 1'b0;
                    row_first_q <= 1'b0;
                    row_last_q  <= 1'b0;
                    done_q      <= 1'b0;
                    row_addr_q  <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Row mux: split the snapshot into rows, select with the registered
    // address.
    // -----------------------------------------------------------------------
    logic [COLS-1:0] snap_rows [ROWS];

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_rows
            assign snap_rows[gi] = snapshot_q[gi*COLS +: COLS];
        end
    endgenerate

    assign row_data  = snap_rows[row_addr_q];
    assign row_addr  = row_addr_q;
    assign busy      = busy_q;
    assign row_valid = row_valid_q;
    assign row_first = row_first_q;
    assign row_last  = row_last_q;
    assign done      = done_q;

`ifdef CONWAY_READER_POPCOUNT_EN
    // -----------------------------------------------------------------------
    // Live-cell counts. row_live follows the registered row mux, so it is
    // stable under stall. frame_live is counted from board_in and latched
    // together with the snapshot.
    // -----------------------------------------------------------------------
    localparam int RL_W = $clog2(COLS + 1);
    localparam int FL_W = $clog2(ROWS*COLS + 1);

    logic [FL_W-1:0] frame_live_d;
    logic [FL_W-1:0] frame_live_q;
    logic [RL_W-1:0] row_live_d;

    always_comb begin
        frame_live_d = '0;
        for (int i = 0; i < ROWS*COLS; i++) begin
            frame_live_d = frame_live_d + FL_W'(board_in[i]);
        end
    end

    always_comb begin
        row_live_d = '0;
        for (int i = 0; i < COLS; i++) begin
            row_live_d = row_live_d + RL_W'(row_data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_live_q <= '0;
        end else if (state_q == IDLE && start) begin
            frame_live_q <= frame_live_d;
        end
    end

    assign row_live   = row_live_d;
    assign frame_live = frame_live_q;
`endif

endmodule

// File: tb/tb_conway_board_reader.sv
// Scoreboard bench for conway_board_reader with a 4x4 board. Stimulus pushes
// the expected row beats; a negedge monitor pops and compares on every
// handshake and also checks that stalled beats hold steady.
module tb_conway_board_reader;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] board_in;
    logic        busy;
    logic        row_valid;
    logic        row_ready;
    logic [3:0]  row_data;
    logic [1:0]  row_addr;
    logic        row_first;
    logic        row_last;
    logic        done;
`ifdef CONWAY_READER_POPCOUNT_EN
    logic [2:0]  row_live;
    logic [4:0]  frame_live;
`endif

    always #5 clk = ~clk;

    conway_board_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .board_in  (board_in),
        .busy      (busy),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_addr  (row_addr),
        .row_first (row_first),
        .row_last  (row_last),
`ifdef CONWAY_READER_POPCOUNT_EN
        .row_live  (row_live),
        .frame_live(frame_live),
`endif
        .done      (done)
    );

    typedef struct packed {
        logic [1:0] addr;
        logic [3:0] data;
        logic       first;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    hs_count = 0;
    int    done_seen = 0;
    int    done_expected = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected beats of rows 0..n-1 (hand-computed row values).
    task automatic push_rows(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3, input int n);
        logic [3:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int r = 0; r < n; r++) begin
            beat_t b;
            b.addr  = 2'(r);
            b.data  = d[r];
            b.first = (r == 0);
            b.last  = (r == 3);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic       stall_q;
        logic [3:0] hold_data;
        logic [1:0] hold_addr;
        logic       hold_first;
        logic       hold_last;
        stall_q = 1'b0;
        hold_data = '0; hold_addr = '0; hold_first = 1'b0; hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q && row_valid) begin
                    check("stall_data", row_data, hold_data);
                    check("stall_addr", row_addr, hold_addr);
                    check("stall_first", row_first, hold_first);
                    check("stall_last", row_last, hold_last);
                end
                if (row_valid && row_ready) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(row_addr), 32'hFFFF);
                    end else begin
                        beat_t b;
                        b = exp_q.pop_front();
                        check("beat_addr", row_addr, b.addr);
                        check("beat_data", row_data, b.data);
                        check("beat_first", row_first, b.first);
                        check("beat_last", row_last, b.last);
`ifdef CONWAY_READER_POPCOUNT_EN
                        check("beat_row_live", row_live, $countones(b.data));
`endif
                    end
                    $display("beat addr=%0d data=%h first=%0b last=%0b",
                             row_addr, row_data, row_first, row_last);
                end
                if (done) done_seen++;
                stall_q    = row_valid && !row_ready;
                hold_data  = row_data;
                hold_addr  = row_addr;
                hold_first = row_first;
                hold_last  = row_last;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_done;
        int hs_before;

        rst = 1'b1; start = 1'b0; row_ready = 1'b0; board_in = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", row_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", row_addr, 0);
        check("rst_data", row_data, 0);
        check("rst_first", row_first, 0);
        check("rst_last", row_last, 0);
`ifdef CONWAY_READER_POPCOUNT_EN
        check("rst_frame_live", frame_live, 0);
`endif

        // Glider, full throughput
        board_in = 16'h0472; row_ready = 1'b1; start = 1'b1;
        push_rows(4'h2, 4'h7, 4'h4, 4'h0, 4);
        tick();                       // cycle k+1
        start = 1'b0;
        check("gl_valid_k1", row_valid, 1);
        check("gl_busy_k1", busy, 1);
`ifdef CONWAY_READER_POPCOUNT_EN
        check("gl_frame_live", frame_live, 5);
`endif
        tick(); tick(); tick();       // cycle k+4
        check("gl_last_k4", row_last, 1);
        tick();                       // cycle k+5
        check("gl_done_k5", done, 1);
        check("gl_busy_k5", busy, 1);
        check("gl_valid_k5", row_valid, 0);
        tick();                       // cycle k+6
        check("gl_done_k6", done, 0);
        check("gl_busy_k6", busy, 0);
        done_expected++;

        // Backpressure 1,0,0,... plus snapshot isolation
        board_in = 16'h0472; start = 1'b1; row_ready = 1'b0;
        push_rows(4'h2, 4'h7, 4'h4, 4'h0, 4);
        hs_before = hs_count;
        tick();
        start = 1'b0;
        board_in = 16'hFFFF;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            row_ready = (i % 3 == 0);
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("bp_done_seen", got_done, 1);
        check("bp_handshakes", hs_count - hs_before, 4);
        row_ready = 1'b1;
        tick();
        done_expected++;

        // start held high: frames every 6 cycles
        board_in = 16'h8E31; start = 1'b1;
        push_rows(4'h1, 4'h3, 4'hE, 4'h8, 4);
        push_rows(4'h1, 4'h3, 4'hE, 4'h8, 4);
        tick();                       // c = 1
        for (int c = 1; c <= 12; c++) begin
            check("hold_valid", row_valid, ((c % 6) >= 1 && (c % 6) <= 4));
            check("hold_busy", busy, ((c % 6) != 0));
            check("hold_done", done, ((c % 6) == 5));
            if (c == 12) start = 1'b0;
            else tick();
        end
        tick();
        check("hold_idle_after", busy, 0);
        done_expected += 2;

        // Reset mid-frame after two accepted beats
        board_in = 16'h1234; start = 1'b1; row_ready = 1'b1;
        push_rows(4'h4, 4'h3, 4'h2, 4'h1, 2);
        tick();
        start = 1'b0;
        tick(); tick();               // two handshakes done
        row_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", row_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_addr", row_addr, 0);
        check("mr_data", row_data, 0);
        check("mr_done", done, 0);
        tick(); tick();
        check("mr_no_done", done_seen, done_expected);

        // Fresh frame after reset streams from row 0
        board_in = 16'h1234; start = 1'b1; row_ready = 1'b1;
        push_rows(4'h4, 4'h3, 4'h2, 4'h1, 4);
        tick();
        start = 1'b0;
        check("mr2_addr0", row_addr, 0);
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("mr2_done_seen", got_done, 1);
        done_expected++;
        tick(); tick();

        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_seen, done_expected);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
